if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch sequencer that sits directly downstream of the PC register. It consumes the current PC, issues requests on the sram-like instruction bus, and produces pc_seq (PC+4) plus the PC load enable. It delivers fetched instructions to the IF/ID boundary through a one-slot output register and a one-entry hold buffer. It also absorbs redirects (jump, mispredict, exception, eret) arriving while a bus transaction is in flight.

Parameters:
WIDTH, 32, address/instruction width
SEQ_INC, 4, byte increment for pc_seq

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
pc  in  WIDTH  current PC (PC register output)
flush  in  1  redirect this cycle (OR of jump/pmis/exc/eret select); PC loads new target on the same edge
pc_seq  out  WIDTH  pc + SEQ_INC, combinational
pc_en  out  1  PC register load enable
inst_req  out  1  instruction bus request
inst_addr  out  WIDTH  request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  WIDTH  read data
id_ready  in  1  downstream consumes id_* this cycle
id_valid  out  1  id_pc/id_inst/id_adel valid
id_pc  out  WIDTH  PC of delivered instruction
id_inst  out  WIDTH  delivered instruction
id_adel  out  1  address-error-on-fetch flag for delivered instruction

Behaviour:
- Reset (rst=0, async): state=REQ, id_valid=0, id_pc=0, id_inst=0, id_adel=0, hold buffer empty. inst_req=0 while rst low. pc_en=0 while rst low.
- slot_free = !id_valid | id_ready.
- deliver(pc, inst, adel): load the output register. id_valid is set on the next edge.
- pc_en = flush | advance.
- advance is high in exactly the cycle an instruction is handed to the output register (from the bus or from the hold buffer).
- pc_seq = pc + SEQ_INC, modulo 2^WIDTH (0xFFFFFFFC wraps to 0x00000000).
- Output register with id_valid=1 and id_ready=0 holds all id_* stable.
- State REQ:
  - inst_req = (pc[1:0]==0) & !flush; inst_addr = pc.
  - Misaligned pc, no flush: no bus request. If slot_free, deliver(pc, 0, 1) and advance; otherwise wait in REQ.
  - addr_ok & !flush: go to WAIT, latch pc as req_pc.
  - flush: stay in REQ. No request is issued in a flush cycle, so no transaction can be orphaned.
- State WAIT (inst_req=0):
  - data_ok & !flush & slot_free: deliver(req_pc, rdata, 0), advance, go to REQ.
  - data_ok & !flush & !slot_free: capture into hold buffer, go to HOLD, no advance.
  - flush & data_ok: drop data, go to REQ.
  - flush & !data_ok: go to DISCARD.
- State HOLD (inst_req=0):
  - id_ready & !flush: deliver from buffer, advance, go to REQ.
  - flush: empty buffer, go to REQ.
- State DISCARD (inst_req=0):
  - Wait for data_ok. Drop the data, go to REQ. Further flushes are ignored here.
- Flush also clears id_valid on the next edge. Flush overrides any simultaneous deliver.
- Delay-slot retention is the controller's job: it asserts flush only once the slot has left ID.
- Throughput: best case is one instruction every 2 cycles with an addr_ok/data_ok turnaround; zero-wait-state bus gives REQ→WAIT→REQ.
- At most one outstanding bus transaction at any time.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state_e enum {REQ, WAIT, HOLD, DISCARD}
  - SEQ_INC constant
  - RESET_VECTOR constant 32'hbfc00000 (also used by pc)
  - fetch_bundle_t struct {pc, inst, adel}
- One sub-module is natural: if_hold_buf, the one-entry fetch_bundle_t register with load/clear/valid.

Test Plan:
- Reset release, pc=0xbfc00000, addr_ok in the same cycle, data_ok 1 cycle later with rdata=0x24080001, id_ready=1 -> id_valid=1, id_pc=0xbfc00000, id_inst=0x24080001; pc_en high exactly in the data_ok cycle; pc_seq=0xbfc00004.
- Backpressure: id_ready=0 while an instruction is already held, second data_ok with rdata=0x00000000 -> state HOLD, pc_en=0. Raise id_ready -> buffered word appears the next cycle and pc_en pulses once.
- Flush in WAIT without data_ok, data_ok 3 cycles later with rdata=0xDEADBEEF -> word never appears on id_inst. Next inst_addr equals the new pc (0x80000180). pc_en=1 in the flush cycle.
- Flush in the same cycle as data_ok -> data dropped; state returns to REQ with no DISCARD visit.
- pc=0xbfc00002 -> inst_req stays 0; id_adel=1, id_inst=0, id_pc=0xbfc00002.
- rst asserted low mid-WAIT -> outputs clear immediately without waiting for a clock edge. Any data_ok after rst deasserts is ignored until a new addr_ok.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage and the PC register.
package cpu_pkg;

    localparam int              XLEN         = 32;
    localparam int unsigned     SEQ_INC      = 4;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'hbfc00000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            adel;
    } fetch_bundle_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for a fetched bundle that arrives while IF/ID is occupied.
module if_hold_buf
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clear,
    input  fetch_bundle_t i_data,
    output fetch_bundle_t o_data,
    output logic          o_valid
);

    fetch_bundle_t r_data;
    logic          r_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: issues one bus request at a time, absorbs redirects
// and delivers instructions to IF/ID through an output register plus a hold buffer.
module if_fetch #(
    parameter int          WIDTH   = 32,
    parameter int unsigned SEQ_INC = cpu_pkg::SEQ_INC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic [WIDTH-1:0] pc_seq,
    output logic             pc_en,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [WIDTH-1:0] id_pc,
    output logic [WIDTH-1:0] id_inst,
    output logic             id_adel
);

    import cpu_pkg::*;

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [WIDTH-1:0] r_req_pc;
    fetch_bundle_t r_id;
    logic          r_id_valid;

    logic          w_slot_free;
    logic          w_aligned;
    logic          w_inst_req;
    logic          w_advance;
    logic          w_req_load;
    logic          w_buf_load;
    logic          w_buf_clear;
    logic          w_buf_valid;
    fetch_bundle_t w_buf_data;
    fetch_bundle_t w_bus_data;
    fetch_bundle_t w_deliver;

    assign w_slot_free = !r_id_valid || id_ready;
    assign w_aligned   = (pc[1:0] == 2'b00);
    assign w_bus_data  = '{pc: r_req_pc, inst: inst_rdata, adel: 1'b0};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_inst_req  = 1'b0;
        w_advance   = 1'b0;
        w_req_load  = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clear = 1'b0;
        w_deliver   = w_bus_data;
        unique case (r_state)
            REQ: begin
                w_inst_req = w_aligned && !flush;
                if (!flush) begin
                    if (!w_aligned) begin
                        // Misaligned fetch never reaches the bus; it is reported downstream.
                        w_advance = w_slot_free;
                        w_deliver = '{pc: pc, inst: '0, adel: 1'b1};
                    end else if (inst_addr_ok) begin
                        w_req_load  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    w_state_nxt = inst_data_ok ? REQ : DISCARD;
                end else if (inst_data_ok) begin
                    if (w_slot_free) begin
                        w_advance   = 1'b1;
                        w_state_nxt = REQ;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                w_deliver = w_buf_data;
                if (flush) begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = REQ;
                end else if (id_ready && w_buf_valid) begin
                    w_advance   = 1'b1;
                    w_buf_clear = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            DISCARD: begin
                if (inst_data_ok) w_state_nxt = REQ;
            end
        endcase
    end

    // NOTE: the datapath registers are reset too, because id_* must read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= REQ;
            r_req_pc   <= '0;
            r_id       <= '0;
            r_id_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_nxt;
            if (w_req_load) r_req_pc <= pc;
            if (flush) begin
                r_id_valid <= 1'b0;
            end else if (w_advance) begin
                r_id       <= w_deliver;
                r_id_valid <= 1'b1;
            end else if (id_ready) begin
                r_id_valid <= 1'b0;
            end
        end
    end

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_data  (w_bus_data),
        .o_data  (w_buf_data),
        .o_valid (w_buf_valid)
    );

    assign pc_seq    = pc + WIDTH'(SEQ_INC);
    assign pc_en     = rst && (flush || w_advance);
    assign inst_req  = rst && w_inst_req;
    assign inst_addr = pc;
    assign id_valid  = r_id_valid;
    assign id_pc     = r_id.pc;
    assign id_inst   = r_id.inst;
    assign id_adel   = r_id.adel;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: transaction-level model plus directed scenarios.
module tb_if_fetch;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] pc_seq;
    logic        pc_en;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;
    logic [31:0] target;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch #(.WIDTH(32), .SEQ_INC(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .flush        (flush),
        .pc_seq       (pc_seq),
        .pc_en        (pc_en),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .id_ready     (id_ready),
        .id_valid     (id_valid),
        .id_pc        (id_pc),
        .id_inst      (id_inst),
        .id_adel      (id_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: outstanding bus read, one buffered word, IF/ID slot.
    logic        m_os, m_os_killed;
    logic [31:0] m_os_pc;
    logic        m_buf_v;
    logic [31:0] m_buf_pc, m_buf_inst;
    logic        m_out_valid, m_out_adel;
    logic [31:0] m_out_pc, m_out_inst;
    logic        m_sf, m_mis, m_adv, m_req;

    assign m_sf  = !m_out_valid || id_ready;
    assign m_mis = (pc[1:0] != 2'b00);
    assign m_adv = rst && (m_buf_v ? (id_ready && !flush)
                         : m_os  ? (!m_os_killed && inst_data_ok && !flush && m_sf)
                         : (m_mis && !flush && m_sf));
    assign m_req = rst && !m_buf_v && !m_os && !m_mis && !flush;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_os <= 1'b0; m_os_killed <= 1'b0; m_os_pc <= '0;
            m_buf_v <= 1'b0; m_buf_pc <= '0; m_buf_inst <= '0;
            m_out_valid <= 1'b0; m_out_pc <= '0; m_out_inst <= '0; m_out_adel <= 1'b0;
        end else begin
            if (m_buf_v) begin
                if (flush || m_adv) m_buf_v <= 1'b0;
                if (m_adv) begin
                    m_out_pc <= m_buf_pc; m_out_inst <= m_buf_inst; m_out_adel <= 1'b0;
                end
            end else if (m_os) begin
                if (inst_data_ok) begin
                    m_os <= 1'b0;
                    if (m_adv) begin
                        m_out_pc <= m_os_pc; m_out_inst <= inst_rdata; m_out_adel <= 1'b0;
                    end else if (!m_os_killed && !flush) begin
                        m_buf_v <= 1'b1; m_buf_pc <= m_os_pc; m_buf_inst <= inst_rdata;
                    end
                end else if (flush) begin
                    m_os_killed <= 1'b1;
                end
            end else if (m_mis) begin
                if (m_adv) begin
                    m_out_pc <= pc; m_out_inst <= '0; m_out_adel <= 1'b1;
                end
            end else if (m_req && inst_addr_ok) begin
                m_os <= 1'b1; m_os_pc <= pc; m_os_killed <= 1'b0;
            end
            m_out_valid <= flush ? 1'b0 : m_adv ? 1'b1 : id_ready ? 1'b0 : m_out_valid;
        end
    end

    // Compare process: every cycle with reset released.
    always @(negedge clk) begin
        if (rst) begin
            check("cyc_inst_req", inst_req, m_req);
            if (m_req) check("cyc_inst_addr", inst_addr, pc);
            check("cyc_pc_en", pc_en, flush || m_adv);
            check("cyc_pc_seq", pc_seq, pc + 32'd4);
            check("cyc_id_valid", id_valid, m_out_valid);
            if (m_out_valid) begin
                check("cyc_id_pc", id_pc, m_out_pc);
                check("cyc_id_inst", id_inst, m_out_inst);
                check("cyc_id_adel", id_adel, m_out_adel);
            end
        end
    end

    task automatic drive(input logic fl, input logic [31:0] tgt, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic rdy);
        flush = fl; target = tgt; inst_addr_ok = aok;
        inst_data_ok = dok; inst_rdata = rd; id_ready = rdy;
        #1;
    endtask

    // Advances one clock; the bench plays the PC register using the model's load enable.
    task automatic tick();
        logic [31:0] nxt;
        @(negedge clk);
        if (!rst)       nxt = RESET_VECTOR;
        else if (flush) nxt = target;
        else if (m_adv) nxt = pc + 32'd4;
        else            nxt = pc;
        @(posedge clk);
        #1;
        pc = nxt;
    endtask

    initial begin
        rst = 1'b0; pc = RESET_VECTOR; target = '0;
        flush = 0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0; id_ready = 0;
        #12;
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_pc_en", pc_en, 1'b0);
        pc = 32'hFFFFFFFC; #1;
        check("pc_seq_wrap", pc_seq, 32'h0);
        pc = RESET_VECTOR;
        @(posedge clk); #1;
        rst = 1'b1;

        // First fetch, zero-wait bus.
        drive(0, 0, 1, 0, 0, 1);
        check("t1_inst_req", inst_req, 1'b1);
        check("t1_inst_addr", inst_addr, 32'hbfc00000);
        check("t1_pc_en_req", pc_en, 1'b0);
        check("t1_pc_seq", pc_seq, 32'hbfc00004);
        tick();
        drive(0, 0, 0, 1, 32'h24080001, 1);
        check("t1_pc_en_data", pc_en, 1'b1);
        tick();
        check("t1_id_valid", id_valid, 1'b1);
        check("t1_id_pc", id_pc, 32'hbfc00000);
        check("t1_id_inst", id_inst, 32'h24080001);
        check("t1_pc", pc, 32'hbfc00004);

        // Backpressure into the hold buffer.
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 32'h0, 0);
        check("t2_pc_en_blocked", pc_en, 1'b0);
        tick();
        check("t2_id_pc_stable", id_pc, 32'hbfc00000);
        drive(0, 0, 0, 0, 0, 0);
        check("t2_hold_no_req", inst_req, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("t2_pc_en_release", pc_en, 1'b1);
        tick();
        check("t2_id_pc", id_pc, 32'hbfc00004);
        check("t2_id_inst", id_inst, 32'h0);
        drive(0, 0, 0, 0, 0, 1);
        check("t2_pc_en_once", pc_en, 1'b0);
        tick();

        // Flush while waiting: late data must be discarded.
        drive(0, 0, 1, 0, 0, 1); tick();
        drive(1, 32'h80000180, 0, 0, 0, 1);
        check("t3_pc_en_flush", pc_en, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        check("t3_discard_no_req", inst_req, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 32'hDEADBEEF, 1);
        check("t3_pc_en_drop", pc_en, 1'b0);
        tick();
        check("t3_id_valid", id_valid, 1'b0);
        drive(0, 0, 0, 0, 0, 1);
        check("t3_inst_req", inst_req, 1'b1);
        check("t3_inst_addr", inst_addr, 32'h80000180);

        // Flush coinciding with data_ok: straight back to REQ.
        drive(0, 0, 1, 0, 0, 1); tick();
        drive(1, 32'h80000200, 0, 1, 32'h11111111, 1); tick();
        drive(0, 0, 0, 0, 0, 1);
        check("t4_inst_req", inst_req, 1'b1);
        check("t4_inst_addr", inst_addr, 32'h80000200);
        check("t4_id_valid", id_valid, 1'b0);

        // Misaligned PC.
        drive(1, 32'hbfc00002, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1);
        check("t5_no_req", inst_req, 1'b0);
        check("t5_pc_en", pc_en, 1'b1);
        tick();
        check("t5_id_valid", id_valid, 1'b1);
        check("t5_id_adel", id_adel, 1'b1);
        check("t5_id_inst", id_inst, 32'h0);
        check("t5_id_pc", id_pc, 32'hbfc00002);

        // Asynchronous reset mid-WAIT.
        drive(1, 32'hbfc00010, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 32'hAAAA0001, 1); tick();
        check("t6_pre_valid", id_valid, 1'b1);
        drive(0, 0, 1, 0, 0, 0); tick();
        rst = 1'b0; #1;
        check("t6_async_valid", id_valid, 1'b0);
        check("t6_async_pc", id_pc, 32'h0);
        check("t6_async_req", inst_req, 1'b0);
        check("t6_async_pc_en", pc_en, 1'b0);
        pc = RESET_VECTOR;
        drive(0, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        drive(0, 0, 0, 1, 32'hBBBB0002, 1);
        check("t6_stale_pc_en", pc_en, 1'b0);
        check("t6_req_again", inst_req, 1'b1);
        tick();
        check("t6_stale_ignored", id_valid, 1'b0);
        drive(0, 0, 1, 0, 0, 1); tick();
        drive(0, 0, 0, 1, 32'hCCCC0003, 1); tick();
        check("t6_new_valid", id_valid, 1'b1);
        check("t6_new_inst", id_inst, 32'hCCCC0003);
        check("t6_new_pc", id_pc, 32'hbfc00000);
        drive(0, 0, 0, 0, 0, 1); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
